lsu_mem_master: RTL and testbench

- RV32I load/store unit: the initiator side of the byte-lane data RAM port.
- Accepts one load or store from the execute stage at a time.
- Stores: computes the word address, byte-lane write enables and lane-aligned write data.
- Loads: issues the read, waits out the RAM's one-cycle registered read, then extracts and sign/zero-extends the result.
- Reports misaligned, illegal-width and out-of-range accesses as errors instead of touching memory.

---
 rtl/lsu_mem_master.sv | 148 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// RV32I load/store unit: initiator of a byte-lane data RAM with a one-cycle registered read.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses; otherwise they are force-aligned.
module lsu_mem_master #(
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rsp_rdata_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic [3:0]  mem_wen_o,
   input  logic [31:0] mem_data_i
);

   typedef enum logic [2:0] {IDLE, STORE, LOAD_ADDR, LOAD_DATA, RESP} state_t;

   state_t      state;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_off;

   logic        req_err;
   logic [1:0]  off;
   logic [31:0] st_data;
   logic [3:0]  st_wen;

   // Byte offset 0 lives in the top lane, so lane data is the byte-reversed little-endian word.
   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  boff);
      logic [31:0] s;
      s = bswap(word) >> {boff, 3'b000};
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b100:  return {24'h0, s[7:0]};
         3'b101:  return {16'h0, s[15:0]};
         default: return s;
      endcase
   endfunction

   always_comb begin
      req_err = !(req_funct3_i == 3'b000 || req_funct3_i == 3'b001 || req_funct3_i == 3'b010 ||
                  req_funct3_i == 3'b100 || req_funct3_i == 3'b101)
                || (req_we_i && req_funct3_i[2])
                || (req_addr_i >= MEM_SIZE);
`ifdef LSU_MISALIGN_TRAP_EN
      case (req_funct3_i[1:0])
         2'b01:   req_err = req_err || req_addr_i[0];
         2'b10:   req_err = req_err || (req_addr_i[1:0] != 2'b00);
         default: req_err = req_err;
      endcase
      off = req_addr_i[1:0];
`else
      case (req_funct3_i[1:0])
         2'b01:   off = {req_addr_i[1], 1'b0};
         2'b10:   off = 2'b00;
         default: off = req_addr_i[1:0];
      endcase
`endif
      case (req_funct3_i[1:0])
         2'b00: begin
            st_wen  = 4'b1000 >> off;
            st_data = bswap({24'h0, req_wdata_i[7:0]} << {off, 3'b000});
         end
         2'b01: begin
            st_wen  = 4'b1100 >> off;
            st_data = bswap({16'h0, req_wdata_i[15:0]} << {off, 3'b000});
         end
         default: begin
            st_wen  = 4'b1111;
            st_data = bswap(req_wdata_i);
         end
      endcase
   end

   // Async reset clears mem_wen_o at once so an interrupted store never reaches the RAM.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         mem_wen_o   <= '0;
         ld_funct3   <= '0;
         ld_off      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  req_ready_o <= 1'b0;
                  if (req_err) begin
                     state       <= RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= '0;
                  end else if (req_we_i) begin
                     state      <= STORE;
                     mem_addr_o <= {req_addr_i[31:2], 2'b00};
                     mem_data_o <= st_data;
                     mem_wen_o  <= st_wen;
                  end else begin
                     state      <= LOAD_ADDR;
                     mem_addr_o <= {req_addr_i[31:2], 2'b00};
                     ld_funct3  <= req_funct3_i;
                     ld_off     <= off;
                  end
               end
            end
            STORE: begin
               state       <= RESP;
               mem_wen_o   <= '0;
               rsp_valid_o <= 1'b1;
               rsp_err_o   <= 1'b0;
               rsp_rdata_o <= '0;
            end
            LOAD_ADDR: state <= LOAD_DATA;
            LOAD_DATA: begin
               state       <= RESP;
               rsp_valid_o <= 1'b1;
               rsp_err_o   <= 1'b0;
               rsp_rdata_o <= load_extend(mem_data_i, ld_funct3, ld_off);
            end
            RESP: begin
               state       <= IDLE;
               rsp_valid_o <= 1'b0;
               req_ready_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-addressed reference model plus a lane-mapped registered-read RAM.
module tb_lsu_mem_master;
   localparam int MEM_SIZE = 1024;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_funct3_i = '0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [3:0]  mem_wen_o;
   logic [31:0] mem_data_i = '0;

   lsu_mem_master #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_wen_o(mem_wen_o),
      .mem_data_i(mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   // RAM: lane k = bits [8k+7:8k] holds byte offset 3-k; read data registered.
   logic [31:0] ram [MEM_SIZE/4] = '{default: 32'h0};
   always @(posedge clk_i) begin
      for (int k = 0; k < 4; k++)
         if (mem_wen_o[k]) ram[mem_addr_o[9:2]][8*k +: 8] <= mem_data_o[8*k +: 8];
      mem_data_i <= ram[mem_addr_o[9:2]];
   end

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Reference model: plain byte-addressed memory.
   logic [7:0] refmem [MEM_SIZE] = '{default: 8'h0};

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int m_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic e;
      e = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      if (we && f3[2]) e = 1'b1;
      if (a >= 32'(MEM_SIZE)) e = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((a % 32'(m_size(f3))) != 0) e = 1'b1;
`endif
      return e;
   endfunction

   // Expectations of the transaction in flight, shared with the compare process.
   logic        chk_en = 1'b0;
   logic        t_active = 1'b0;
   logic        t_we = 1'b0;
   logic        t_err = 1'b0;
   int          t_lat = 1;
   int          t_acc = 0;
   logic [3:0]  t_wen = '0;
   logic [31:0] t_wd = '0;
   logic [31:0] t_addr = '0;
   logic [31:0] t_rd = '0;
   logic [31:0] t_pre_addr = '0;

   logic [31:0] cap_addr, cap_data, cap_rd;
   logic [3:0]  cap_wen;
   logic        cap_err;

   always @(negedge clk_i) begin
      int k;
      logic exp_v;
      logic [3:0] exp_w;
      if (chk_en) begin
         k = cyc - t_acc;
         exp_v = t_active && (k == t_lat - 1);
         exp_w = (t_active && t_we && !t_err && k == 0) ? t_wen : 4'b0000;
         chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
         chk("mem_wen", 32'(mem_wen_o), 32'(exp_w));
         chk("req_ready", 32'(req_ready_o), 32'(!t_active || k >= t_lat));
         if (exp_v) begin
            chk("rsp_err", 32'(rsp_err_o), 32'(t_err));
            chk("rsp_rdata", rsp_rdata_o, t_rd);
         end
         if (exp_w != 4'b0000) begin
            chk("st_addr", mem_addr_o, t_addr);
            chk("st_data", mem_data_o, t_wd);
         end
         if (t_active && !t_err && !t_we && k < 2) chk("ld_addr", mem_addr_o, t_addr);
         if (t_active && t_err && k < t_lat) chk("err_addr_held", mem_addr_o, t_pre_addr);
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
      int n, bound, lane;
      logic e;
      logic [31:0] ea, rd, exp_wd, pre;
      logic [3:0] exp_wen;
      bound = 0;
      while (req_ready_o !== 1'b1 && bound < 20) begin
         @(negedge clk_i);
         bound++;
      end
      if (req_ready_o !== 1'b1) begin
         chk("ready_timeout", 32'(req_ready_o), 32'd1);
         return;
      end
      e  = m_err(we, f3, a);
      n  = m_size(f3);
      ea = a & ~32'(n - 1);
      rd = '0;
      exp_wd = '0;
      exp_wen = '0;
      if (!e && we)
         for (int i = 0; i < n; i++) begin
            lane = 3 - int'((ea + 32'(i)) % 4);
            exp_wen[lane] = 1'b1;
            exp_wd[8*lane +: 8] = wd[8*i +: 8];
         end
      if (!e && !we) begin
         for (int i = 0; i < n; i++) rd = rd | (32'(refmem[ea + 32'(i)]) << (8*i));
         if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
      pre = mem_addr_o;
      req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      t_we = we; t_err = e; t_lat = e ? 1 : (we ? 2 : 3);
      t_wen = exp_wen; t_wd = exp_wd; t_addr = {ea[31:2], 2'b00}; t_rd = rd;
      t_pre_addr = pre; t_acc = cyc; t_active = 1'b1;
      if (!e && we)
         for (int i = 0; i < n; i++) refmem[ea + 32'(i)] = wd[8*i +: 8];
      cap_addr = mem_addr_o; cap_wen = mem_wen_o; cap_data = mem_data_o;
      cap_err = 1'b0; cap_rd = '0;
      for (int k = 0; k <= t_lat; k++) begin
         @(negedge clk_i);
         if (k == 0) req_valid_i = 1'b0;
         if (k == t_lat - 1) begin
            cap_err = rsp_err_o;
            cap_rd  = rsp_rdata_o;
         end
      end
   endtask

   initial begin
      #1 rst_i = 1'b0;
      #2;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_err", 32'(rsp_err_o), 32'd0);
      chk("rst_rdata", rsp_rdata_o, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_data", mem_data_o, 32'd0);
      chk("rst_wen", 32'(mem_wen_o), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);

      // Reset in the middle of a store: enables must vanish without a clock edge.
      req_we_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'h10; req_wdata_i = 32'h1122_3344;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("rst_mid_wen_before", 32'(mem_wen_o), 32'hF);
      #1 rst_i = 1'b0;
      #1;
      chk("rst_mid_wen_drop", 32'(mem_wen_o), 32'd0);
      chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
      chk("rst_mid_valid", 32'(rsp_valid_o), 32'd0);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      t_active = 1'b0;
      chk_en = 1'b1;
      @(negedge clk_i);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      chk("rst_lw", cap_rd, 32'h0);

      do_req(1'b1, 3'b000, 32'h05, 32'h1234_56AB);
      chk("sb_addr", cap_addr, 32'h4);
      chk("sb_wen", 32'(cap_wen), 32'h4);
      chk("sb_data", cap_data, 32'h00AB_0000);
      do_req(1'b0, 3'b000, 32'h05, 32'h0);
      chk("lb", cap_rd, 32'hFFFF_FFAB);
      chk("lb_model", t_rd, 32'hFFFF_FFAB);
      do_req(1'b0, 3'b100, 32'h05, 32'h0);
      chk("lbu", cap_rd, 32'h0000_00AB);

      do_req(1'b1, 3'b001, 32'h0A, 32'hFFFF_8234);
      chk("sh_addr", cap_addr, 32'h8);
      chk("sh_wen", 32'(cap_wen), 32'h3);
      chk("sh_data", cap_data, 32'h0000_3482);
      do_req(1'b0, 3'b001, 32'h0A, 32'h0);
      chk("lh", cap_rd, 32'hFFFF_8234);
      chk("lh_model", t_rd, 32'hFFFF_8234);
      do_req(1'b0, 3'b101, 32'h0A, 32'h0);
      chk("lhu", cap_rd, 32'h0000_8234);

      do_req(1'b1, 3'b010, 32'h00, 32'h1122_3344);
      chk("sw_wen", 32'(cap_wen), 32'hF);
      chk("sw_data", cap_data, 32'h4433_2211);
      do_req(1'b0, 3'b010, 32'h00, 32'h0);
      chk("lw", cap_rd, 32'h1122_3344);

      do_req(1'b0, 3'b010, 32'h02, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lw_mis_err", 32'(cap_err), 32'd1);
      chk("lw_mis_rdata", cap_rd, 32'h0);
`else
      chk("lw_mis_err", 32'(cap_err), 32'd0);
      chk("lw_mis_rdata", cap_rd, 32'h1122_3344);
`endif
      do_req(1'b0, 3'b001, 32'h03, 32'h0);
      do_req(1'b1, 3'b001, 32'h0F, 32'h0000_BEEF);
      do_req(1'b0, 3'b010, 32'h0C, 32'h0);

      do_req(1'b0, 3'b010, 32'h400, 32'h0);
      chk("lw_oor_err", 32'(cap_err), 32'd1);
      chk("lw_oor_rdata", cap_rd, 32'h0);
      do_req(1'b0, 3'b011, 32'h0, 32'h0);
      chk("f3_011_err", 32'(cap_err), 32'd1);
      do_req(1'b1, 3'b100, 32'h20, 32'hFF);
      chk("sbu_err", 32'(cap_err), 32'd1);
      do_req(1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF);
      chk("sw_oor_err", 32'(cap_err), 32'd1);

      do_req(1'b1, 3'b010, 32'h3FC, 32'hCAFE_F00D);
      do_req(1'b0, 3'b010, 32'h3FC, 32'h0);
      chk("lw_after_sw", cap_rd, 32'hCAFE_F00D);
      do_req(1'b0, 3'b000, 32'h3FF, 32'h0);
      chk("lb_top", cap_rd, 32'hFFFF_FFCA);
      do_req(1'b0, 3'b101, 32'h3FE, 32'h0);
      chk("lhu_top", cap_rd, 32'h0000_CAFE);
      do_req(1'b1, 3'b000, 32'h3FD, 32'h0000_0012);
      do_req(1'b0, 3'b010, 32'h3FC, 32'h0);
      chk("lw_merge", cap_rd, 32'hCAFE_120D);

      repeat (3) @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
